// File: rtl/regfile_pkg.sv
// Shared regfile definitions: geometry and the writeback request record used by
// the regfile, the writeback arbiter and the writeback stages.
package regfile_pkg;

  localparam int N_BITS = 32;
  localparam int N_REGS = 32;
  localparam int N_IDX  = $clog2(N_REGS);

  typedef struct packed {
    logic [N_IDX-1:0]  idx;
    logic [N_BITS-1:0] data;
  } wb_req_t;

  // x0 is hardwired to zero, so writes aimed at it are swallowed.
  function automatic logic is_x0(input logic [N_IDX-1:0] idx);
    return idx == '0;
  endfunction

endpackage

// File: rtl/regfile_wb_arbiter_rr.sv
// Combinational round-robin arbiter: searches req starting at ptr and returns a
// one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter int N_REQ = 3,
  parameter int PW    = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [N_REQ-1:0] gnt,
  output logic [PW-1:0]    gnt_idx,
  output logic             gnt_valid
);

  always_comb begin
    // NOTE: every output gets a default before the search loop; without it a
    // path that never matches would leave them unassigned and infer latches.
    gnt       = '0;
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!gnt_valid && req[(int'(ptr) + k) % N_REQ]) begin
        gnt[(int'(ptr) + k) % N_REQ] = 1'b1;
        gnt_idx                      = PW'((int'(ptr) + k) % N_REQ);
        gnt_valid                    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter sharing the single regfile write port among N_REQ
// writeback sources. Optional stall counter under `REGFILE_WB_PERF_EN`.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int N_REQ = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  output logic [N_REQ-1:0]        req_ready,
  input  logic [N_REQ*N_IDX-1:0]  req_idx,
  input  logic [N_REQ*N_BITS-1:0] req_data,
  output logic                    wr_en,
  output logic [N_IDX-1:0]        wr_idx,
  output logic [N_BITS-1:0]       wr_data,
`ifdef REGFILE_WB_PERF_EN
  output logic [31:0]             stall_cnt,
`endif
  output logic                    coll_err
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  wb_req_t          req [N_REQ];
  logic [N_REQ-1:0] gnt;
  logic [PW-1:0]    gnt_idx;
  logic             gnt_valid;
  logic [PW-1:0]    rr_ptr;
  logic [PW-1:0]    ptr_nxt;
  logic             coll_hit;
  wb_req_t          sel;

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      req[i].idx  = req_idx[i*N_IDX +: N_IDX];
      req[i].data = req_data[i*N_BITS +: N_BITS];
    end
  end

  rr_arbiter #(.N_REQ(N_REQ), .PW(PW)) u_rr_arbiter (
    .req       (req_valid),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  // Ready is masked during reset so no requester sees a phantom transfer.
  assign req_ready = rst_n ? gnt : '0;
  assign sel       = req[gnt_idx];
  assign ptr_nxt   = (gnt_idx == PW'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    coll_hit = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      for (int j = i + 1; j < N_REQ; j++) begin
        if (req_valid[i] && req_valid[j] && req[i].idx == req[j].idx && !is_x0(req[i].idx))
          coll_hit = 1'b1;
      end
    end
  end

  // NOTE: reset clears only control and the small output registers; there is
  // no storage array here, and wr_idx/wr_data are reset because they are visible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en    <= 1'b0;
      wr_idx   <= '0;
      wr_data  <= '0;
      coll_err <= 1'b0;
      rr_ptr   <= '0;
    end else begin
      // NOTE: state updates use non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      wr_en    <= gnt_valid && !is_x0(sel.idx);
      coll_err <= coll_hit;
      if (gnt_valid) begin
        wr_idx  <= sel.idx;
        wr_data <= sel.data;
        rr_ptr  <= ptr_nxt;
      end
    end
  end

`ifdef REGFILE_WB_PERF_EN
  logic stall;

  // Any valid requester left without a grant costs one stall cycle.
  assign stall = |(req_valid & ~gnt);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (stall && stall_cnt != '1)
      stall_cnt <= stall_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench for regfile_wb_arbiter: vector table with a write scoreboard,
// plus reset-mid-stream and (with REGFILE_WB_PERF_EN) stall counter sequences.
module tb_regfile_wb_arbiter;
  import regfile_pkg::*;

  localparam int NR = 3;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_ready;
  logic [NR-1:0][N_IDX-1:0]  req_idx = '0;
  logic [NR-1:0][N_BITS-1:0] req_data = '0;
  logic                 wr_en;
  logic [N_IDX-1:0]     wr_idx;
  logic [N_BITS-1:0]    wr_data;
  logic                 coll_err;
`ifdef REGFILE_WB_PERF_EN
  logic [31:0]          stall_cnt;
`endif

  regfile_wb_arbiter #(.N_REQ(NR)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_idx   (req_idx),
    .req_data  (req_data),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .wr_data   (wr_data),
`ifdef REGFILE_WB_PERF_EN
    .stall_cnt (stall_cnt),
`endif
    .coll_err  (coll_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NR-1:0]             valid;
    logic [NR-1:0][N_IDX-1:0]  idx;
    logic [NR-1:0][N_BITS-1:0] data;
    logic [NR-1:0]             exp_ready;
    logic                      exp_coll;
  } vec_t;

  typedef struct {
    logic              en;
    logic [N_IDX-1:0]  idx;
    logic [N_BITS-1:0] data;
    logic              coll;
  } wr_exp_t;

  vec_t    vecs [13];
  wr_exp_t sb [$];
  int      checks = 0;
  int      errors = 0;
  logic [N_IDX-1:0]  hold_idx  = '0;
  logic [N_BITS-1:0] hold_data = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_vec(input int n, input logic [2:0] v,
                         input logic [4:0] i2, input logic [4:0] i1, input logic [4:0] i0,
                         input logic [31:0] d2, input logic [31:0] d1, input logic [31:0] d0,
                         input logic [2:0] rdy, input logic coll);
    vecs[n].valid     = v;
    vecs[n].idx       = {i2, i1, i0};
    vecs[n].data      = {d2, d1, d0};
    vecs[n].exp_ready = rdy;
    vecs[n].exp_coll  = coll;
  endtask

  // Drive one vector after a falling edge, check ready, then score the write.
  task automatic apply(input vec_t v, input int n);
    wr_exp_t e;
    wr_exp_t got;
    req_valid = v.valid;
    req_idx   = v.idx;
    req_data  = v.data;
    #1;
    check($sformatf("ready[v%0d]", n), 32'(req_ready), 32'(v.exp_ready));
    e.en   = 1'b0;
    e.coll = v.exp_coll;
    for (int i = 0; i < NR; i++) begin
      if (v.exp_ready[i]) begin
        hold_idx  = v.idx[i];
        hold_data = v.data[i];
        e.en      = (v.idx[i] != '0);
      end
    end
    e.idx  = hold_idx;
    e.data = hold_data;
    sb.push_back(e);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check($sformatf("sb_empty[v%0d]", n), 32'd0, 32'd1);
    end else begin
      got = sb.pop_front();
      check($sformatf("wr_en[v%0d]", n),    32'(wr_en),    32'(got.en));
      check($sformatf("wr_idx[v%0d]", n),   32'(wr_idx),   32'(got.idx));
      check($sformatf("wr_data[v%0d]", n),  wr_data,       got.data);
      check($sformatf("coll_err[v%0d]", n), 32'(coll_err), 32'(got.coll));
    end
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    //      n  valid   i2 i1 i0   d2            d1            d0             ready   coll
    set_vec(0,  3'b001, 0, 0, 5,  32'h0,        32'h0,        32'hDEADBEEF,  3'b001, 0);
    set_vec(1,  3'b000, 0, 0, 0,  32'h0,        32'h0,        32'h0,         3'b000, 0);
    set_vec(2,  3'b111, 3, 2, 1,  32'hC,        32'hB,        32'hA,         3'b010, 0);
    set_vec(3,  3'b111, 3, 2, 1,  32'hC,        32'hB,        32'hA,         3'b100, 0);
    set_vec(4,  3'b111, 3, 2, 1,  32'hC,        32'hB,        32'hA,         3'b001, 0);
    set_vec(5,  3'b111, 3, 2, 1,  32'hC,        32'hB,        32'hA,         3'b010, 0);
    set_vec(6,  3'b010, 0, 0, 0,  32'h0,        32'h1234,     32'h0,         3'b010, 0);
    set_vec(7,  3'b100, 9, 0, 0,  32'h99,       32'h0,        32'h0,         3'b100, 0);
    set_vec(8,  3'b101, 7, 0, 7,  32'h2,        32'h0,        32'h1,         3'b001, 1);
    set_vec(9,  3'b100, 7, 0, 0,  32'h2,        32'h0,        32'h0,         3'b100, 0);
    set_vec(10, 3'b011, 0, 3, 3,  32'h0,        32'h22,       32'h11,        3'b001, 1);
    set_vec(11, 3'b110, 0, 0, 0,  32'h44,       32'h33,       32'h0,         3'b010, 0);
    set_vec(12, 3'b111, 4, 4, 4,  32'h3,        32'h2,        32'h1,         3'b100, 1);

    // Reset state, with all requesters valid to show ready is masked.
    req_valid = 3'b111;
    req_idx   = {5'd3, 5'd2, 5'd1};
    repeat (2) @(negedge clk);
    #1;
    check("rst_ready",    32'(req_ready), 32'd0);
    check("rst_wr_en",    32'(wr_en),     32'd0);
    check("rst_wr_idx",   32'(wr_idx),    32'd0);
    check("rst_wr_data",  wr_data,        32'd0);
    check("rst_coll_err", 32'(coll_err),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int n = 0; n < 13; n++) apply(vecs[n], n);

    // Reset one cycle after a transfer: the presented write disappears at once.
    req_valid = 3'b111;
    req_idx   = {5'd3, 5'd2, 5'd1};
    req_data  = {32'hC3, 32'hB2, 32'hA1};
    #1;
    check("mid_ready_pre", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    check("mid_wr_en_pre", 32'(wr_en), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_wr_en",   32'(wr_en),     32'd0);
    check("mid_rst_wr_idx",  32'(wr_idx),    32'd0);
    check("mid_rst_ready",   32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_restart_ready", 32'(req_ready), 32'b001);
    @(posedge clk);
    #1;
    check("mid_restart_wr_en",   32'(wr_en),   32'd1);
    check("mid_restart_wr_idx",  32'(wr_idx),  32'd1);
    check("mid_restart_wr_data", wr_data,      32'hA1);

`ifdef REGFILE_WB_PERF_EN
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("stall_cnt_4", stall_cnt, 32'd4);
    @(negedge clk);
    force dut.stall_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt;
    @(posedge clk);
    #1;
    check("stall_cnt_sat", stall_cnt, 32'hFFFF_FFFF);
`endif

    req_valid = '0;
    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
